// File: rtl/radix2_divider_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
//   div_state_t    : IDLE / BUSY / DONE sequencer states
//   DIV_WIDTH      : full operand width (double-word divide)
//   DIV_WORD_WIDTH : operand width for word divides
//   u128           : packed {remainder, quotient} result type
package radix2_divider_pkg;

  localparam int unsigned DIV_WIDTH      = 64;
  localparam int unsigned DIV_WORD_WIDTH = 32;

  typedef logic [2*DIV_WIDTH-1:0] u128;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/radix2_divider_if.sv
// Execute-stage divide handshake: level-held valid from the requester, one-cycle
// done pulse from the divider.
//   valid  : request, held until done or abort
//   wordEn : 1 = 32-bit divide on a[31:0]/b[31:0]
//   a, b   : unsigned dividend / divisor magnitudes
//   done   : completion pulse, c valid in that cycle
//   c      : {remainder, quotient}
// Modports: master = requester, slave = divider.
interface radix2_divider_if;
  import radix2_divider_pkg::*;

  logic                 valid;
  logic                 wordEn;
  logic [DIV_WIDTH-1:0] a;
  logic [DIV_WIDTH-1:0] b;
  logic                 done;
  u128                  c;

  modport master (
    output valid, wordEn, a, b,
    input  done, c
  );

  modport slave (
    input  valid, wordEn, a, b,
    output done, c
  );

endinterface

// File: rtl/radix2_divider_div_step.sv
// One restoring division step (combinational).
//   rem      : partial remainder before the step (always < divisor)
//   msb      : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the conditional subtract
//   q_bit    : quotient bit produced by this step
module radix2_divider_div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit; after a successful subtract the
  // result is again < divisor and fits back into WIDTH bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem, msb};
    diff    = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/radix2_divider.sv
// Iterative restoring radix-2 unsigned divider. Divides pre-conditioned
// magnitudes one bit per cycle and returns {remainder, quotient}.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, discards any operation in flight
//   bus   : radix2_divider_if.slave (valid/wordEn/a/b in, done/c out)
// Build option: define DIVIDER_EARLY_OUT_EN to finish in one cycle when the
// effective dividend is below a nonzero divisor.
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int unsigned WIDTH      = DIV_WIDTH,
  parameter int unsigned WORD_WIDTH = DIV_WORD_WIDTH
) (
  input logic               clk,
  input logic               reset,
  radix2_divider_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned PadW = WIDTH - WORD_WIDTH;

  div_state_t           state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend in, quotient shifts in at LSB
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 word_q, word_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   c_q, c_d;

  logic [WIDTH-1:0]     a_eff, b_eff;
  logic                 b_zero;
  logic                 step_msb;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_q;
  logic [WIDTH-1:0]     quo_next;

  function automatic logic [2*WIDTH-1:0] pack_result(input logic             word,
                                                     input logic [WIDTH-1:0] rem,
                                                     input logic [WIDTH-1:0] quo);
    if (word) begin
      return {{PadW{1'b0}}, rem[WORD_WIDTH-1:0], {PadW{1'b0}}, quo[WORD_WIDTH-1:0]};
    end
    return {rem, quo};
  endfunction

  // Word mode zero-extends from bit WORD_WIDTH-1; upper input bits are ignored.
  always_comb begin
    a_eff  = bus.wordEn ? {{PadW{1'b0}}, bus.a[WORD_WIDTH-1:0]} : bus.a;
    b_eff  = bus.wordEn ? {{PadW{1'b0}}, bus.b[WORD_WIDTH-1:0]} : bus.b;
    b_zero = (b_eff == '0);
  end

  // In word mode the dividend lives in the low half, so its MSB is bit WORD_WIDTH-1.
  assign step_msb = word_q ? dvd_q[WORD_WIDTH-1] : dvd_q[WIDTH-1];
  assign quo_next = {dvd_q[WIDTH-2:0], step_q};

  radix2_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .msb      (step_msb),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      word_q  <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    c_d     = c_q;

    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          rem_d  = '0;
          dvd_d  = a_eff;
          dvs_d  = b_eff;
          word_d = bus.wordEn;
          cnt_d  = bus.wordEn ? CntW'(WORD_WIDTH) : CntW'(WIDTH);
          if (b_zero) begin
            c_d     = pack_result(bus.wordEn, a_eff, '1);
            state_d = DONE;
`ifdef DIVIDER_EARLY_OUT_EN
          end else if (a_eff < b_eff) begin
            c_d     = pack_result(bus.wordEn, a_eff, '0);
            state_d = DONE;
`endif
          end else begin
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (!bus.valid) begin
          // Abort: result register keeps the previous completion.
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = quo_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            c_d     = pack_result(word_q, step_rem, quo_next);
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.done = (state_q == DONE);
    bus.c    = c_q;
  end

endmodule

// File: tb/tb_radix2_divider.sv
// Directed bench for radix2_divider: expected {remainder, quotient} and latency
// are pushed to a scoreboard when a request is driven and popped on done.
module tb_radix2_divider;
  import radix2_divider_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  radix2_divider_if bus ();

  radix2_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] c;
    int           lat;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [127:0] last_c;

  function automatic logic [127:0] model_c(input logic [63:0] a, input logic [63:0] b,
                                           input logic w);
    logic [63:0] ea, eb, q, r;
    ea = w ? {32'b0, a[31:0]} : a;
    eb = w ? {32'b0, b[31:0]} : b;
    if (eb == 64'd0) begin
      q = w ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      r = ea;
    end else begin
      q = ea / eb;
      r = ea % eb;
    end
    return {r, q};
  endfunction

  // Edges counted from (and including) the accepting edge until done is seen.
  function automatic int model_lat(input logic [63:0] a, input logic [63:0] b, input logic w);
    logic [63:0] ea, eb;
    ea = w ? {32'b0, a[31:0]} : a;
    eb = w ? {32'b0, b[31:0]} : b;
    if (eb == 64'd0) return 1;
`ifdef DIVIDER_EARLY_OUT_EN
    if (ea < eb) return 1;
`endif
    return w ? 33 : 65;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic w,
                       input string tag, input int lat_override);
    @(negedge clk);
    bus.valid  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.wordEn = w;
    sb.push_back('{c: model_c(a, b, w),
                   lat: (lat_override > 0) ? lat_override : model_lat(a, b, w),
                   tag: tag});
  endtask

  // Waits (bounded) for done; optionally scrambles operands after the first edge.
  task automatic wait_done(input bit scramble);
    exp_t e;
    int   n;
    bit   seen;
    e    = sb.pop_front();
    n    = 0;
    seen = 1'b0;
    while (n < e.lat + 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (scramble && n == 1) begin
        bus.a      = {$urandom, $urandom};
        bus.b      = {$urandom, $urandom};
        bus.wordEn = ~bus.wordEn;
      end
    end
    check({e.tag, " done_seen"}, 128'(seen), 128'd1);
    check({e.tag, " latency"}, 128'(n), 128'(e.lat));
    check({e.tag, " result"}, bus.c, e.c);
    last_c = e.c;
  endtask

  // Drop valid after a completion and confirm done is a single-cycle pulse.
  task automatic release_and_check(input string tag);
    @(negedge clk);
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " done_low_after"}, 128'(bus.done), 128'd0);
    check({tag, " c_held"}, bus.c, last_c);
  endtask

  initial begin
    bit seen;
    bus.valid  = 1'b0;
    bus.wordEn = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    last_c     = '0;

    #1;
    check("reset done", 128'(bus.done), 128'd0);
    check("reset c", bus.c, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 64-bit divide
    drive(64'd100, 64'd7, 1'b0, "dw100_7", 0);
    wait_done(1'b0);
    check("dw100_7 const", bus.c, {64'd2, 64'd14});
    release_and_check("dw100_7");

    // Word divide; upper bits ignored and operands scrambled after accept
    drive(64'hFFFF_FFFF_0000_0064, 64'h0000_0001_0000_0007, 1'b1, "word100_7", 0);
    wait_done(1'b1);
    check("word100_7 const", bus.c, {32'b0, 32'd2, 32'b0, 32'd14});
    release_and_check("word100_7");

    // Divide by zero, both widths
    drive(64'd5, 64'd0, 1'b0, "dz_dw", 0);
    wait_done(1'b0);
    release_and_check("dz_dw");
    drive(64'hABCD_0000_0000_0005, 64'h1234_0000_0000_0000, 1'b1, "dz_word", 0);
    wait_done(1'b0);
    check("dz_word const", bus.c, {32'b0, 32'd5, 32'b0, 32'hFFFF_FFFF});
    release_and_check("dz_word");

    // Abort: drop valid mid-operation
    @(negedge clk);
    bus.valid  = 1'b1;
    bus.a      = 64'd1000;
    bus.b      = 64'd3;
    bus.wordEn = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort no_done", 128'(seen), 128'd0);
    check("abort c_unchanged", bus.c, last_c);

    // Abort left it in IDLE: a fresh request gets full normal latency
    drive(64'd1000, 64'd3, 1'b0, "after_abort", 0);
    wait_done(1'b0);
    release_and_check("after_abort");

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.valid = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset done", 128'(bus.done), 128'd0);
    check("async_reset c", bus.c, 128'd0);
    last_c = '0;
    @(negedge clk);
    bus.valid = 1'b0;
    reset     = 1'b0;

    // a < b: early-out when enabled, full latency otherwise; same result
    drive(64'd3, 64'd10, 1'b0, "a_lt_b", 0);
    wait_done(1'b0);
    release_and_check("a_lt_b");

    // Back-to-back with valid held. Second request is accepted on the IDLE edge
    // following the DONE cycle: 1 (leave DONE) + 65 edges after the first done.
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, "b2b_first", 0);
    wait_done(1'b0);
    check("b2b_first const", bus.c, {64'hF, 64'h0FFF_FFFF_FFFF_FFFF});
    @(negedge clk);
    bus.a = 64'd9;
    bus.b = 64'd3;
    sb.push_back('{c: model_c(64'd9, 64'd3, 1'b0), lat: 66, tag: "b2b_second"});
    wait_done(1'b0);
    check("b2b_second const", bus.c, {64'd0, 64'd3});
    release_and_check("b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
